// File: rtl/fp_wb_pkg.sv
// Shared types and constants for the FP register-file write-back arbiter.
//   src_e      : write-back producer identifier (load, FPU, int-to-FP move)
//   FP_DATA_W  : register-file data width
//   FP_NREG    : number of FP registers
//   wb_req_t   : packed write request {valid, frd, data}
//   next_src() : round-robin successor of a producer
package fp_wb_pkg;

  localparam int FP_DATA_W = 32;
  localparam int FP_NREG   = 32;
  localparam int FP_REG_W  = $clog2(FP_NREG);
  localparam int NUM_SRC   = 3;

  typedef enum logic [1:0] {
    SRC_LD  = 2'd0,
    SRC_FPU = 2'd1,
    SRC_MV  = 2'd2
  } src_e;

  typedef struct packed {
    logic                 valid;
    logic [FP_REG_W-1:0]  frd;
    logic [FP_DATA_W-1:0] data;
  } wb_req_t;

  function automatic src_e next_src(input src_e s);
    case (s)
      SRC_LD:  return SRC_FPU;
      SRC_FPU: return SRC_MV;
      default: return SRC_LD;
    endcase
  endfunction

endpackage

// File: rtl/fp_scoreboard.sv
// In-flight destination tracker for the FP register file.
//   clk_i, rst_ni        : clock, synchronous active-low reset
//   issue_valid_i/frd_i  : decode issue; issue_ready_o low when frd is busy
//   clr_valid_i/frd_i    : write grant this cycle, clears its busy bit
//   wr_pending_i/frd_i   : write currently presented to the register file
//   chk_idx_i, chk_use_i : decode indices {frd, frs3, frs2, frs1} + enables
//   stall_o              : hazard on any enabled index
//   busy_o               : busy vector
module fp_scoreboard
  import fp_wb_pkg::*;
(
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      issue_valid_i,
  input  logic [FP_REG_W-1:0]       issue_frd_i,
  output logic                      issue_ready_o,
  input  logic                      clr_valid_i,
  input  logic [FP_REG_W-1:0]       clr_frd_i,
  input  logic                      wr_pending_i,
  input  logic [FP_REG_W-1:0]       wr_frd_i,
  input  logic [3:0][FP_REG_W-1:0]  chk_idx_i,
  input  logic [3:0]                chk_use_i,
  output logic                      stall_o,
  output logic [FP_NREG-1:0]        busy_o
);

  logic [FP_NREG-1:0] busy_q, busy_d;
  logic [3:0]         hit;

  // Refuse issue while in reset so no ready is ever high during reset.
  assign issue_ready_o = rst_ni & ~busy_q[issue_frd_i];

  // Set and clear never hit the same index: issue to a busy index is refused.
  always_comb begin
    busy_d = busy_q;
    if (clr_valid_i) busy_d[clr_frd_i] = 1'b0;
    if (issue_valid_i && issue_ready_o) busy_d[issue_frd_i] = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) busy_q <= '0;
    else         busy_q <= busy_d;
  end

  // The busy bit clears at the grant edge, but the data only reaches the
  // register file one cycle later, so the pending write also counts as a hazard.
  for (genvar gi = 0; gi < 4; gi++) begin : g_chk
    assign hit[gi] = chk_use_i[gi] &
                     (busy_q[chk_idx_i[gi]] | (wr_pending_i & (wr_frd_i == chk_idx_i[gi])));
  end

  assign stall_o = |hit;
  assign busy_o  = busy_q;

endmodule

// File: rtl/fp_wb_arbiter.sv
// Single-write-port arbiter for the FP register file plus hazard scoreboard.
//   Producers  : ld_*, fpu_*, mv_* (valid/frd/data in, ready out)
//   Write port : fregwrite_o, frd_o, wdata_o (registered, one cycle after grant)
//   Decode     : issue_valid_i/issue_frd_i/issue_ready_o, chk_* -> stall_o
//   Status     : busy_o scoreboard vector, wb_err_o sticky write-to-idle flag
// Build option FP_WB_ROUND_ROBIN_EN: round-robin over ld/fpu/mv instead of
// fixed priority ld > fpu > mv with starvation promotion of mv.
module fp_wb_arbiter
  import fp_wb_pkg::*;
#(
  parameter int DATA_W       = FP_DATA_W,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              issue_valid_i,
  input  logic [4:0]        issue_frd_i,
  output logic              issue_ready_o,
  input  logic [4:0]        chk_frs1_i,
  input  logic [4:0]        chk_frs2_i,
  input  logic [4:0]        chk_frs3_i,
  input  logic [4:0]        chk_frd_i,
  input  logic [3:0]        chk_use_i,
  output logic              stall_o,
  input  logic              ld_valid_i,
  input  logic [4:0]        ld_frd_i,
  input  logic [DATA_W-1:0] ld_data_i,
  output logic              ld_ready_o,
  input  logic              fpu_valid_i,
  input  logic [4:0]        fpu_frd_i,
  input  logic [DATA_W-1:0] fpu_data_i,
  output logic              fpu_ready_o,
  input  logic              mv_valid_i,
  input  logic [4:0]        mv_frd_i,
  input  logic [DATA_W-1:0] mv_data_i,
  output logic              mv_ready_o,
  output logic              fregwrite_o,
  output logic [4:0]        frd_o,
  output logic [DATA_W-1:0] wdata_o,
  output logic [31:0]       busy_o,
  output logic              wb_err_o
);

  logic [NUM_SRC-1:0] req_valid, gnt, gnt_eff;
  logic [4:0]         req_frd  [NUM_SRC];
  logic [DATA_W-1:0]  req_data [NUM_SRC];
  logic               any_gnt;
  logic [4:0]         sel_frd;
  logic [DATA_W-1:0]  sel_data;

  assign req_valid = {mv_valid_i, fpu_valid_i, ld_valid_i};
  assign req_frd[SRC_LD]   = ld_frd_i;
  assign req_frd[SRC_FPU]  = fpu_frd_i;
  assign req_frd[SRC_MV]   = mv_frd_i;
  assign req_data[SRC_LD]  = ld_data_i;
  assign req_data[SRC_FPU] = fpu_data_i;
  assign req_data[SRC_MV]  = mv_data_i;

`ifdef FP_WB_ROUND_ROBIN_EN
  src_e rr_ptr_q, rr_ptr_d;
  int   rr_idx;
  logic rr_found;

  // Scan from the pointer; the first valid requester wins and the pointer
  // moves to the one after it.
  always_comb begin
    gnt      = '0;
    rr_ptr_d = rr_ptr_q;
    rr_found = 1'b0;
    rr_idx   = 0;
    for (int k = 0; k < NUM_SRC; k++) begin
      rr_idx = int'(rr_ptr_q) + k;
      if (rr_idx >= NUM_SRC) rr_idx = rr_idx - NUM_SRC;
      if (!rr_found && req_valid[rr_idx]) begin
        gnt[rr_idx] = 1'b1;
        rr_found    = 1'b1;
        rr_ptr_d    = next_src(src_e'(rr_idx[1:0]));
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) rr_ptr_q <= SRC_LD;
    else         rr_ptr_q <= rr_ptr_d;
  end
`else
  logic [2:0] starve_q, starve_d;
  logic       promote;

  assign promote = (32'(starve_q) >= STARVE_LIMIT);

  always_comb begin
    gnt = '0;
    if (mv_valid_i && (promote || !(ld_valid_i || fpu_valid_i))) gnt[SRC_MV]  = 1'b1;
    else if (ld_valid_i)                                         gnt[SRC_LD]  = 1'b1;
    else if (fpu_valid_i)                                        gnt[SRC_FPU] = 1'b1;
  end

  // Saturating count of consecutive cycles mv waited while requesting.
  always_comb begin
    starve_d = 3'd0;
    if (mv_valid_i && !gnt[SRC_MV])
      starve_d = (starve_q == 3'd7) ? 3'd7 : starve_q + 3'd1;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) starve_q <= 3'd0;
    else         starve_q <= starve_d;
  end
`endif

  assign gnt_eff     = gnt & {NUM_SRC{rst_ni}};
  assign any_gnt     = |gnt_eff;
  assign ld_ready_o  = gnt_eff[SRC_LD];
  assign fpu_ready_o = gnt_eff[SRC_FPU];
  assign mv_ready_o  = gnt_eff[SRC_MV];

  always_comb begin
    sel_frd  = '0;
    sel_data = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (gnt_eff[k]) begin
        sel_frd  = req_frd[k];
        sel_data = req_data[k];
      end
    end
  end

  logic              fregwrite_q, fregwrite_d;
  logic [4:0]        frd_q, frd_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              wb_err_q, wb_err_d;

  always_comb begin
    fregwrite_d = any_gnt;
    frd_d       = any_gnt ? sel_frd : frd_q;
    wdata_d     = any_gnt ? sel_data : wdata_q;
    // Writing a register nobody is waiting on means a producer lost track.
    wb_err_d    = wb_err_q | (any_gnt & ~busy_o[sel_frd]);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      fregwrite_q <= 1'b0;
      frd_q       <= '0;
      wdata_q     <= '0;
      wb_err_q    <= 1'b0;
    end else begin
      fregwrite_q <= fregwrite_d;
      frd_q       <= frd_d;
      wdata_q     <= wdata_d;
      wb_err_q    <= wb_err_d;
    end
  end

  assign fregwrite_o = fregwrite_q;
  assign frd_o       = frd_q;
  assign wdata_o     = wdata_q;
  assign wb_err_o    = wb_err_q;

  fp_scoreboard u_sb (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .issue_valid_i (issue_valid_i),
    .issue_frd_i   (issue_frd_i),
    .issue_ready_o (issue_ready_o),
    .clr_valid_i   (any_gnt),
    .clr_frd_i     (sel_frd),
    .wr_pending_i  (fregwrite_q),
    .wr_frd_i      (frd_q),
    .chk_idx_i     ({chk_frd_i, chk_frs3_i, chk_frs2_i, chk_frs1_i}),
    .chk_use_i     (chk_use_i),
    .stall_o       (stall_o),
    .busy_o        (busy_o)
  );

endmodule

// File: tb/tb_fp_wb_arbiter.sv
// Directed bench for fp_wb_arbiter: a cycle table for arbitration, write
// register and hazard timing, plus sequences for write-to-idle error,
// mv starvation and mid-operation reset.
module tb_fp_wb_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        issue_valid_i;
  logic [4:0]  issue_frd_i;
  logic        issue_ready_o;
  logic [4:0]  chk_frs1_i, chk_frs2_i, chk_frs3_i, chk_frd_i;
  logic [3:0]  chk_use_i;
  logic        stall_o;
  logic        ld_valid_i, fpu_valid_i, mv_valid_i;
  logic [4:0]  ld_frd_i, fpu_frd_i, mv_frd_i;
  logic [31:0] ld_data_i, fpu_data_i, mv_data_i;
  logic        ld_ready_o, fpu_ready_o, mv_ready_o;
  logic        fregwrite_o;
  logic [4:0]  frd_o;
  logic [31:0] wdata_o;
  logic [31:0] busy_o;
  logic        wb_err_o;

  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  fp_wb_arbiter dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .issue_valid_i(issue_valid_i), .issue_frd_i(issue_frd_i), .issue_ready_o(issue_ready_o),
    .chk_frs1_i(chk_frs1_i), .chk_frs2_i(chk_frs2_i), .chk_frs3_i(chk_frs3_i),
    .chk_frd_i(chk_frd_i), .chk_use_i(chk_use_i), .stall_o(stall_o),
    .ld_valid_i(ld_valid_i), .ld_frd_i(ld_frd_i), .ld_data_i(ld_data_i), .ld_ready_o(ld_ready_o),
    .fpu_valid_i(fpu_valid_i), .fpu_frd_i(fpu_frd_i), .fpu_data_i(fpu_data_i), .fpu_ready_o(fpu_ready_o),
    .mv_valid_i(mv_valid_i), .mv_frd_i(mv_frd_i), .mv_data_i(mv_data_i), .mv_ready_o(mv_ready_o),
    .fregwrite_o(fregwrite_o), .frd_o(frd_o), .wdata_o(wdata_o),
    .busy_o(busy_o), .wb_err_o(wb_err_o)
  );

  typedef struct {
    logic        iv;
    logic [4:0]  ifrd;
    logic [3:0]  chk;
    logic [4:0]  frs2;
    logic        lv;
    logic [4:0]  lfrd;
    logic        fv;
    logic [4:0]  ffrd;
    logic        mv;
    logic [4:0]  mfrd;
    logic        e_ir;
    logic        e_st;
    logic [2:0]  e_rdy;   // {mv, fpu, ld}
    logic        e_we;
    logic [4:0]  e_frd;
    logic [31:0] e_wd;
    logic [31:0] e_busy;
  } vec_t;

  vec_t vecs [11];

  function automatic vec_t mk(logic iv, logic [4:0] ifrd, logic [3:0] chk, logic [4:0] frs2,
                              logic lv, logic [4:0] lfrd, logic fv, logic [4:0] ffrd,
                              logic mv, logic [4:0] mfrd, logic e_ir, logic e_st,
                              logic [2:0] e_rdy, logic e_we, logic [4:0] e_frd,
                              logic [31:0] e_wd, logic [31:0] e_busy);
    vec_t v;
    v.iv = iv; v.ifrd = ifrd; v.chk = chk; v.frs2 = frs2;
    v.lv = lv; v.lfrd = lfrd; v.fv = fv; v.ffrd = ffrd; v.mv = mv; v.mfrd = mfrd;
    v.e_ir = e_ir; v.e_st = e_st; v.e_rdy = e_rdy; v.e_we = e_we;
    v.e_frd = e_frd; v.e_wd = e_wd; v.e_busy = e_busy;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Source tags in the data make the winning producer visible on wdata_o.
  task automatic drive(input logic iv, input logic [4:0] ifrd, input logic [3:0] chk,
                       input logic [4:0] frs2, input logic lv, input logic [4:0] lfrd,
                       input logic fv, input logic [4:0] ffrd, input logic mv,
                       input logic [4:0] mfrd);
    issue_valid_i = iv;  issue_frd_i = ifrd;
    chk_use_i = chk;     chk_frs2_i = frs2;
    chk_frs1_i = 5'd0;   chk_frs3_i = 5'd0;  chk_frd_i = 5'd0;
    ld_valid_i = lv;     ld_frd_i = lfrd;    ld_data_i  = 32'h1000_0000 | {27'd0, lfrd};
    fpu_valid_i = fv;    fpu_frd_i = ffrd;   fpu_data_i = 32'h2000_0000 | {27'd0, ffrd};
    mv_valid_i = mv;     mv_frd_i = mfrd;    mv_data_i  = 32'h3000_0000 | {27'd0, mfrd};
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  int first_mv;

  initial begin
    // f3/f4/f5 issued, ld f3 and fpu f4 collide, f5 hazard through its write,
    // f7 double issue, lone mv grant.
    vecs[0]  = mk(1,3, 4'b0000,0, 0,0, 0,0, 0,0, 1,0,3'b000, 0,0,32'h0,          32'h0);
    vecs[1]  = mk(1,4, 4'b0000,0, 0,0, 0,0, 0,0, 1,0,3'b000, 0,0,32'h0,          32'h8);
    vecs[2]  = mk(1,5, 4'b0000,0, 1,3, 1,4, 0,0, 1,0,3'b001, 0,0,32'h0,          32'h18);
    vecs[3]  = mk(0,0, 4'b0010,5, 0,0, 1,4, 0,0, 1,1,3'b010, 1,3,32'h1000_0003,  32'h30);
    vecs[4]  = mk(0,0, 4'b0010,5, 0,0, 1,5, 0,0, 1,1,3'b010, 1,4,32'h2000_0004,  32'h20);
    vecs[5]  = mk(0,0, 4'b0010,5, 0,0, 0,0, 0,0, 1,1,3'b000, 1,5,32'h2000_0005,  32'h0);
    vecs[6]  = mk(1,7, 4'b0010,5, 0,0, 0,0, 0,0, 1,0,3'b000, 0,5,32'h2000_0005,  32'h0);
    vecs[7]  = mk(1,7, 4'b0010,5, 0,0, 0,0, 0,0, 0,0,3'b000, 0,5,32'h2000_0005,  32'h80);
    vecs[8]  = mk(0,0, 4'b0010,5, 0,0, 0,0, 1,7, 1,0,3'b100, 0,5,32'h2000_0005,  32'h80);
    vecs[9]  = mk(0,0, 4'b0000,0, 0,0, 0,0, 0,0, 1,0,3'b000, 1,7,32'h3000_0007,  32'h0);
    vecs[10] = mk(0,0, 4'b0000,0, 0,0, 0,0, 0,0, 1,0,3'b000, 0,7,32'h3000_0007,  32'h0);

    rst_ni = 1'b0;
    idle();
    tick();
    tick();
    rst_ni = 1'b1;
    #1;
    check("reset_busy", busy_o, 32'h0);
    check("reset_we", {31'd0, fregwrite_o}, 32'd0);
    check("reset_frd", {27'd0, frd_o}, 32'd0);
    check("reset_wdata", wdata_o, 32'h0);
    check("reset_err", {31'd0, wb_err_o}, 32'd0);

    for (int i = 0; i < 11; i++) begin
      drive(vecs[i].iv, vecs[i].ifrd, vecs[i].chk, vecs[i].frs2, vecs[i].lv, vecs[i].lfrd,
            vecs[i].fv, vecs[i].ffrd, vecs[i].mv, vecs[i].mfrd);
      #1;
      check($sformatf("v%0d_issue_ready", i), {31'd0, issue_ready_o}, {31'd0, vecs[i].e_ir});
      check($sformatf("v%0d_stall", i), {31'd0, stall_o}, {31'd0, vecs[i].e_st});
      check($sformatf("v%0d_ready", i), {29'd0, mv_ready_o, fpu_ready_o, ld_ready_o},
            {29'd0, vecs[i].e_rdy});
      check($sformatf("v%0d_we", i), {31'd0, fregwrite_o}, {31'd0, vecs[i].e_we});
      check($sformatf("v%0d_frd", i), {27'd0, frd_o}, {27'd0, vecs[i].e_frd});
      check($sformatf("v%0d_wdata", i), wdata_o, vecs[i].e_wd);
      check($sformatf("v%0d_busy", i), busy_o, vecs[i].e_busy);
      check($sformatf("v%0d_err", i), {31'd0, wb_err_o}, 32'd0);
      $display("vec %0d: rdy=%b ir=%b st=%b we=%b frd=%0d busy=%h",
               i, {mv_ready_o, fpu_ready_o, ld_ready_o}, issue_ready_o, stall_o,
               fregwrite_o, frd_o, busy_o);
      tick();
    end

    // mv write to idle f9: write still happens, error flag sticks.
    idle();
    mv_valid_i = 1'b1; mv_frd_i = 5'd9; mv_data_i = 32'h3000_0009;
    #1;
    check("err_mv_ready", {31'd0, mv_ready_o}, 32'd1);
    tick();
    idle();
    #1;
    check("err_we", {31'd0, fregwrite_o}, 32'd1);
    check("err_frd", {27'd0, frd_o}, 32'd9);
    check("err_wdata", wdata_o, 32'h3000_0009);
    check("err_set", {31'd0, wb_err_o}, 32'd1);
    $display("wb_err: frd=%0d err=%b", frd_o, wb_err_o);
    tick();
    tick();
    check("err_sticky", {31'd0, wb_err_o}, 32'd1);

    // mv held against continuous ld and fpu requests.
    first_mv = 0;
    for (int c = 1; c <= 8; c++) begin
      drive(0, 0, 0, 0, 1, 11, 1, 12, 1, 10);
      #1;
      check($sformatf("starve_c%0d_onehot", c),
            {31'd0, ($countones({mv_ready_o, fpu_ready_o, ld_ready_o}) == 1)}, 32'd1);
      $display("starve cycle %0d: rdy=%b", c, {mv_ready_o, fpu_ready_o, ld_ready_o});
      if (mv_ready_o) begin
        first_mv = c;
        tick();
        break;
      end
      tick();
    end
    idle();
`ifdef FP_WB_ROUND_ROBIN_EN
    check("starve_grant_within_3", {31'd0, (first_mv >= 1 && first_mv <= 3)}, 32'd1);
`else
    check("starve_grant_cycle", first_mv, 32'd5);
`endif

    // Reset with f4..f7 busy and a write in flight.
    rst_ni = 1'b0;
    tick();
    rst_ni = 1'b1;
    for (int r = 4; r <= 7; r++) begin
      drive(1, 5'(r), 0, 0, (r == 7), 5'd1, 0, 0, 0, 0);
      tick();
    end
    idle();
    #1;
    check("prereset_busy", busy_o, 32'h0000_00F0);
    check("prereset_we", {31'd0, fregwrite_o}, 32'd1);
    check("prereset_err", {31'd0, wb_err_o}, 32'd1);
    rst_ni = 1'b0;
    drive(1, 8, 0, 0, 1, 2, 1, 3, 1, 4);
    #1;
    check("inreset_ready", {28'd0, issue_ready_o, mv_ready_o, fpu_ready_o, ld_ready_o}, 32'd0);
    tick();
    rst_ni = 1'b1;
    idle();
    #1;
    check("postreset_busy", busy_o, 32'h0);
    check("postreset_we", {31'd0, fregwrite_o}, 32'd0);
    check("postreset_err", {31'd0, wb_err_o}, 32'd0);
    check("postreset_frd", {27'd0, frd_o}, 32'd0);
    $display("reset: busy=%h we=%b err=%b", busy_o, fregwrite_o, wb_err_o);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fp_wb_arbiter.md
# fp_wb_arbiter

Write-port arbiter and scoreboard for the single-write-port floating-point register file. It accepts write-back requests from three producers (load return, FPU result, integer-to-FP move) and grants one per cycle. It drives a registered write strobe, address and data into the register file. It also tracks in-flight destination registers and raises a stall for RAW/WAW hazards at decode.

## Interface
Parameters:
- DATA_W, 32, write data width
- STARVE_LIMIT, 4, consecutive denied cycles after which the move requester is promoted (fixed-priority build only)

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset; one clock; reset is synchronous and active-low
- issue_valid_i  in  1  decode issues an FP-writing instruction
- issue_frd_i  in  5  its destination register
- issue_ready_o  out  1  issue accepted; low when issue_frd_i is busy
- chk_frs1_i, chk_frs2_i, chk_frs3_i, chk_frd_i  in  5 each  decode operand/destination indices
- chk_use_i  in  4  per-index check enable {frd, frs3, frs2, frs1}
- stall_o  out  1  hazard on any enabled index
- ld_valid_i / ld_frd_i / ld_data_i  in  1/5/DATA_W  load return request
- ld_ready_o  out  1  load granted
- fpu_valid_i / fpu_frd_i / fpu_data_i  in  1/5/DATA_W  FPU result request
- fpu_ready_o  out  1  FPU granted
- mv_valid_i / mv_frd_i / mv_data_i  in  1/5/DATA_W  int-to-FP move request
- mv_ready_o  out  1  move granted
- fregwrite_o  out  1  register-file write enable
- frd_o  out  5  write address
- wdata_o  out  DATA_W  write data
- busy_o  out  32  scoreboard vector
- wb_err_o  out  1  sticky flag: a granted write targeted a non-busy register

## Operation
- Handshake: a request is transferred when valid and ready are both high. A requester holds valid, frd and data stable until it is granted. Ready is combinational from valid and arbitration state. At most one ready is high per cycle.
- Fixed priority: ld > fpu > mv.
- Starvation counter (3 bits, saturating):
  - Increments each cycle mv_valid_i is high and mv is not granted.
  - Clears on an mv grant or when mv_valid_i is low.
  - When the count is >= STARVE_LIMIT, mv takes top priority for one grant.
- Scoreboard:
  - busy[issue_frd_i] is set on an issue handshake.
  - busy[frd] is cleared on a write grant.
  - issue_ready_o = !busy[issue_frd_i].
  - Set and clear of the same index in the same cycle is impossible, because issue to a busy index is refused.
  - Set and clear of different indices in the same cycle both take effect.
- Write register: a grant loads frd_o and wdata_o at the edge, and fregwrite_o is high for the following cycle. With no grant, fregwrite_o = 0 and frd_o/wdata_o hold.
- Hazard: stall_o = OR over enabled indices of (busy[idx] | (fregwrite_o & frd_o == idx)). This covers the write in flight to the register file.
- f0 is an ordinary register with no special case.
- Grant to a non-busy frd: the write is still performed, and wb_err_o is set until reset.

## Timing
- Grant to register-file write: 1 cycle (the write lands at the second edge after the handshake cycle).
- Issue to busy visible: next cycle.
- Grant to busy clear: next cycle. stall_o stays high through the fregwrite_o cycle, so total stall after the grant is 2 cycles.
- Reset (synchronous, rst_ni low at an edge):
  - busy_o = 0, fregwrite_o = 0, frd_o = 0, wdata_o = 0, wb_err_o = 0.
  - Starvation counter = 0, round-robin pointer = ld.
  - All ready outputs are 0 while rst_ni is low.
- Reset mid-operation discards in-flight grants and all scoreboard state.
- Throughput: one write per cycle sustained.

## Configuration
- FP_WB_ROUND_ROBIN_EN defined:
  - Arbitration is round-robin over ld, fpu, mv.
  - The pointer advances to the requester after the one granted.
  - The starvation counter and STARVE_LIMIT are unused.
- Undefined: fixed priority with mv starvation promotion, as in Operation.

## Structure
- Package fp_wb_pkg holds:
  - the source enum (SRC_LD=0, SRC_FPU=1, SRC_MV=2);
  - the FP_DATA_W constant (32);
  - the FP_NREG constant (32);
  - a packed write-request struct {valid, frd, data}.
- Sub-module fp_scoreboard holds the busy vector, set/clear logic, issue_ready_o, and the hazard compare.
- The arbiter top holds request muxing, the grant logic and the write register.

## Test plan
- Reset, then ld_valid_i and fpu_valid_i high in the same cycle, both targeting busy registers f3 and f4 -> ld_ready_o=1 and fpu_ready_o=0. Next cycle: fregwrite_o=1, frd_o=3. FPU is granted the following cycle.
- Issue f5, then decode checks frs2=5 with chk_use_i=4'b0010 -> stall_o=1 until the fpu grant for f5. Then stall_o stays high for the fregwrite_o cycle and drops the cycle after.
- Issue f7 twice back-to-back -> first issue_ready_o=1, second 0 while busy[7]=1.
- mv_valid_i held while ld/fpu request every cycle with STARVE_LIMIT=4 -> mv_ready_o=1 on the 5th cycle. With FP_WB_ROUND_ROBIN_EN defined, mv is granted within 3 cycles.
- mv grant to f9 with busy[9]=0 -> write performed (frd_o=9) and wb_err_o=1, sticky until reset.
- rst_ni low for one edge while busy_o=32'h0000_00F0 and fregwrite_o=1 -> next cycle busy_o=0, fregwrite_o=0, wb_err_o=0.
